// File: rtl/branch_pc_sequencer.sv
// branch_pc_sequencer: owns the KGP-RISC program counter, fetches each
// instruction over a req/ack handshake, holds it for the datapath, then
// resolves the branch and loads the next PC. Also drives the bl link write,
// counts taken branches and parks the core on halt.
module branch_pc_sequencer #(
    parameter int unsigned            ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]      RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,

    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_data,

    output logic [31:0]       instr,
    output logic              instr_valid,

    input  logic              ex_done,
    input  logic [5:0]        branchop,
    input  logic              carry,
    input  logic              zero,
    input  logic              lessthanzero,
    input  logic              target_sel,
    input  logic [ADDR_W-1:0] offset,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              link_en,
    input  logic              halt,

    output logic              link_we,
    output logic [ADDR_W-1:0] link_data,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       taken_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Branch opcodes understood by the condition test
    localparam logic [5:0] OP_BCY  = 6'd1;
    localparam logic [5:0] OP_BNCY = 6'd2;
    localparam logic [5:0] OP_BZ   = 6'd3;
    localparam logic [5:0] OP_BNZ  = 6'd4;
    localparam logic [5:0] OP_BLTZ = 6'd5;
    localparam logic [5:0] OP_B    = 6'd6;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;

    logic              take_c;
    logic [ADDR_W-1:0] pc_inc_c;
    logic [ADDR_W-1:0] rel_target_c;
    logic [ADDR_W-1:0] reg_target_c;
    logic [ADDR_W-1:0] next_pc_c;
    logic              unused_rs_low_c;

    // Fetch address is the PC register itself, so it is stable for all of FETCH
    assign imem_addr = pc;

    // Register targets are word-aligned; the two low bits are discarded
    assign unused_rs_low_c = ^rs_val[1:0];

    // Branch condition test from the ALU flags
    always_comb begin
        take_c = 1'b0;
        case (branchop)
            OP_BCY:  take_c = carry;
            OP_BNCY: take_c = ~carry;
            OP_BZ:   take_c = zero;
            OP_BNZ:  take_c = ~zero;
            OP_BLTZ: take_c = lessthanzero;
            OP_B:    take_c = 1'b1;
            default: take_c = 1'b0;
        endcase
    end

    // Next-PC selection; all arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        pc_inc_c     = pc + ADDR_W'(4);
        rel_target_c = pc + offset;
        reg_target_c = {rs_val[ADDR_W-1:2], 2'b00};
        next_pc_c    = pc_inc_c;
        if (take_c) begin
            next_pc_c = target_sel ? reg_target_c : rel_target_c;
        end
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            instr       <= '0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            link_we     <= 1'b0;
            link_data   <= '0;
            halted      <= 1'b0;
            taken_cnt   <= '0;
        end else begin
            link_we <= 1'b0;
            case (state)
                FETCH: begin
                    // An ack only counts against a request that is actually up
                    if (imem_req && imem_ack) begin
                        instr       <= imem_data;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= EXEC;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end

                EXEC: begin
                    if (ex_done) begin
                        instr_valid <= 1'b0;
                        if (halt) begin
                            imem_req <= 1'b0;
                            halted   <= 1'b1;
                            state    <= HALT;
                        end else begin
                            pc       <= next_pc_c;
                            imem_req <= 1'b1;
                            state    <= FETCH;
                            if (take_c && link_en) begin
                                link_we   <= 1'b1;
                                link_data <= pc_inc_c;
                            end
                            if (take_c && (taken_cnt != CNT_MAX)) begin
                                taken_cnt <= taken_cnt + CNT_W'(1);
                            end
                        end
                    end
                end

                HALT: begin
                    // Parked until reset
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    halted      <= 1'b1;
                end

                default: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                    state       <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// Testbench for branch_pc_sequencer: directed test-plan scenarios with literal
// expectations, randomized traffic, and a per-cycle compare against a
// behavioural model of the sequencer.
module tb_branch_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        ex_done;
    logic [5:0]  branchop;
    logic        carry, zero, lessthanzero;
    logic        target_sel;
    logic [31:0] offset;
    logic [31:0] rs_val;
    logic        link_en;
    logic        halt;
    logic        link_we;
    logic [31:0] link_data;
    logic [31:0] pc;
    logic        halted;
    logic [15:0] taken_cnt;

    int vectors    = 0;
    int miscompares = 0;

    branch_pc_sequencer #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .instr(instr), .instr_valid(instr_valid),
        .ex_done(ex_done), .branchop(branchop),
        .carry(carry), .zero(zero), .lessthanzero(lessthanzero),
        .target_sel(target_sel), .offset(offset), .rs_val(rs_val),
        .link_en(link_en), .halt(halt),
        .link_we(link_we), .link_data(link_data),
        .pc(pc), .halted(halted), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for an instruction, 1 instruction held, 2 parked
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_ldata;
    logic        m_req, m_valid, m_lwe, m_halted;
    int          m_cnt;

    function automatic logic branch_taken(input logic [5:0] op, input logic c, input logic z, input logic lt);
        logic [7:0] table_v;
        table_v = {1'b0, 1'b1, lt, ~z, z, ~c, c, 1'b0};
        if (op > 6'd7) return 1'b0;
        return table_v[op[2:0]];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_pc <= 32'h0; m_instr <= 32'h0; m_ldata <= 32'h0;
            m_req <= 1'b0; m_valid <= 1'b0; m_lwe <= 1'b0; m_halted <= 1'b0; m_cnt <= 0;
        end else begin
            m_lwe <= 1'b0;
            if (m_mode == 0) begin
                if (m_req && imem_ack) begin
                    m_instr <= imem_data; m_req <= 1'b0; m_valid <= 1'b1; m_mode <= 1;
                end else begin
                    m_req <= 1'b1;
                end
            end else if (m_mode == 1 && ex_done) begin
                m_valid <= 1'b0;
                if (halt) begin
                    m_mode <= 2; m_halted <= 1'b1;
                end else begin
                    m_mode <= 0; m_req <= 1'b1;
                    if (branch_taken(branchop, carry, zero, lessthanzero)) begin
                        m_pc  <= target_sel ? (rs_val & 32'hFFFF_FFFC) : m_pc + offset;
                        m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
                        if (link_en) begin
                            m_lwe <= 1'b1; m_ldata <= m_pc + 32'd4;
                        end
                    end else begin
                        m_pc <= m_pc + 32'd4;
                    end
                end
            end
        end
    end

    // Compare every output against the model, away from the active edge
    always @(negedge clk) begin
        check("imem_req",    imem_req,    m_req);
        check("imem_addr",   imem_addr,   m_pc);
        check("pc",          pc,          m_pc);
        check("instr",       instr,       m_instr);
        check("instr_valid", instr_valid, m_valid);
        check("link_we",     link_we,     m_lwe);
        check("link_data",   link_data,   m_ldata);
        check("halted",      halted,      m_halted);
        check("taken_cnt",   taken_cnt,   64'(m_cnt));
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        imem_ack = 0; imem_data = 0; ex_done = 0; branchop = 0;
        carry = 0; zero = 0; lessthanzero = 0; target_sel = 0;
        offset = 0; rs_val = 0; link_en = 0; halt = 0;
    endtask

    // Called at a falling edge while a fetch is pending; returns at the
    // falling edge just after ex_done has been taken.
    task automatic exec_instr(input int ack_wait, input logic [31:0] d, input logic [5:0] op,
                              input logic c, input logic z, input logic lt, input logic ts,
                              input logic [31:0] off, input logic [31:0] rs,
                              input logic le, input logic h);
        repeat (ack_wait) begin imem_ack = 0; @(negedge clk); end
        imem_ack = 1; imem_data = d;
        @(negedge clk);
        imem_ack = 0; ex_done = 1; branchop = op; carry = c; zero = z; lessthanzero = lt;
        target_sel = ts; offset = off; rs_val = rs; link_en = le; halt = h;
        @(negedge clk);
        ex_done = 0; link_en = 0; halt = 0; branchop = 0;
    endtask

    task automatic reset_pulse();
        #2 rst = 1;
        @(negedge clk);
        rst = 0;
    endtask

    logic [7:0] b8;

    initial begin
        rst = 1;
        clear_inputs();
        repeat (3) @(negedge clk);
        check("rst_pc", pc, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_cnt", taken_cnt, 16'h0);
        rst = 0;

        // First fetch with ack delayed two cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("first_req", imem_req, 1'b1);
            check("first_addr", imem_addr, 32'h0);
        end
        imem_ack = 1; imem_data = 32'hA5A5_0001;
        @(negedge clk);
        imem_ack = 0;
        check("first_instr", instr, 32'hA5A5_0001);
        check("first_valid", instr_valid, 1'b1);
        ex_done = 1; branchop = 6'd0;
        @(negedge clk);
        ex_done = 0;
        check("nt_pc", pc, 32'h4);
        check("nt_req", imem_req, 1'b1);
        check("nt_valid", instr_valid, 1'b0);

        // bz taken / not taken from 0x100
        exec_instr(0, 32'h1, 6'd6, 0, 0, 0, 1, 32'h0, 32'h100, 0, 0);
        check("jr_pc", pc, 32'h100);
        exec_instr(1, 32'h2, 6'd3, 0, 1, 0, 0, 32'hFFFF_FFF0, 32'h0, 0, 0);
        check("bz_t_pc", pc, 32'hF0);
        check("bz_t_cnt", taken_cnt, 16'd2);
        exec_instr(0, 32'h3, 6'd6, 0, 0, 0, 1, 32'h0, 32'h100, 0, 0);
        exec_instr(2, 32'h4, 6'd3, 0, 0, 0, 0, 32'hFFFF_FFF0, 32'h0, 0, 0);
        check("bz_nt_pc", pc, 32'h104);
        check("bz_nt_cnt", taken_cnt, 16'd3);

        // Register branch drops the low bits
        exec_instr(0, 32'h5, 6'd6, 0, 0, 0, 1, 32'h0, 32'h20, 0, 0);
        exec_instr(0, 32'h6, 6'd6, 0, 0, 0, 1, 32'h0, 32'h203, 0, 0);
        check("br_pc", pc, 32'h200);

        // bl from 0x40
        exec_instr(0, 32'h7, 6'd6, 0, 0, 0, 1, 32'h0, 32'h40, 0, 0);
        exec_instr(0, 32'h8, 6'd6, 0, 0, 0, 0, 32'h80, 32'h0, 1, 0);
        check("bl_we", link_we, 1'b1);
        check("bl_data", link_data, 32'h44);
        check("bl_pc", pc, 32'hC0);
        @(negedge clk);
        check("bl_we_once", link_we, 1'b0);

        // Halt parks the core despite acks
        exec_instr(1, 32'h9, 6'd6, 0, 0, 0, 0, 32'h40, 32'h0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            imem_ack = 1; imem_data = $urandom; ex_done = 1; branchop = 6'd6;
            check("halt_halted", halted, 1'b1);
            check("halt_req", imem_req, 1'b0);
            check("halt_pc", pc, 32'hC0);
            check("halt_linkwe", link_we, 1'b0);
            @(negedge clk);
        end
        clear_inputs();
        #2 rst = 1;
        #1 check("halt_rst_pc", pc, 32'h0);
        check("halt_rst_halted", halted, 1'b0);
        @(negedge clk);
        rst = 0;

        // Randomized traffic with occasional asynchronous resets
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 250; i++) begin
                imem_ack     = ($urandom % 2) == 0;
                imem_data    = $urandom;
                ex_done      = ($urandom % 3) == 0;
                branchop     = 6'($urandom_range(0, 9));
                carry        = $urandom % 2;
                zero         = $urandom % 2;
                lessthanzero = $urandom % 2;
                target_sel   = $urandom % 2;
                b8           = 8'($urandom);
                offset       = ($urandom % 2) ? $urandom : {{24{b8[7]}}, b8};
                rs_val       = $urandom;
                link_en      = $urandom % 2;
                halt         = ($urandom % 40) == 0;
                @(negedge clk);
            end
            clear_inputs();
            reset_pulse();
        end

        // Taken-counter saturation: back-to-back taken branches
        branchop = 6'd6; target_sel = 1; rs_val = 32'h0; imem_ack = 1; ex_done = 1;
        repeat (131080) @(negedge clk);
        check("sat_cnt", taken_cnt, 16'hFFFF);
        repeat (4) @(negedge clk);
        check("sat_cnt_hold", taken_cnt, 16'hFFFF);

        // Reset while a request is outstanding
        imem_ack = 0;
        repeat (2) @(negedge clk);
        check("pre_rst_req", imem_req, 1'b1);
        #2 rst = 1;
        #1 check("rst_drop_req", imem_req, 1'b0);
        check("rst_drop_cnt", taken_cnt, 16'h0);
        imem_ack = 1; ex_done = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check("post_rst_valid", instr_valid, 1'b0);
        check("post_rst_req", imem_req, 1'b1);
        imem_ack = 0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
